regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Writer side of the core's `register_bank` write port. It merges results from the single-cycle ALU path and the variable-latency load path onto the bank's one write port (`write_enable`/`write_addr`/`data_in`). It buffers load results in a small FIFO and tracks pending destination registers in a scoreboard so the issue stage can stall on RAW/WAW hazards. It sits between execute/memory and the register bank.

## Interface
- `WORD_SIZE`, 32, data width
- `ADDR_W`, 5, register address width (32 registers)
- `LQ_DEPTH`, 2, load-result FIFO entries (power of two, ≥2)

- `clk` in 1: clock
- `rstn` in 1: reset, asynchronous, active-low
- `alu_valid` in 1: ALU result present this cycle. Always accepted; no ready.
- `alu_rd` in ADDR_W: ALU destination
- `alu_data` in WORD_SIZE: ALU result
- `ld_valid` in 1: load result offered
- `ld_ready` out 1: load result accepted when `ld_valid & ld_ready`
- `ld_rd` in ADDR_W: load destination
- `ld_data` in WORD_SIZE: load data
- `iss_valid` in 1: issue stage dispatches an instruction that writes `iss_rd`
- `iss_rd` in ADDR_W: destination being marked pending
- `chk_rs1`, `chk_rs2` in ADDR_W: source registers queried by issue
- `busy_rs1`, `busy_rs2` out 1: queried source still pending
- `busy_rd` out 1: `iss_rd` still pending (WAW check)
- `wr_en` out 1: to bank `write_enable`
- `wr_addr` out ADDR_W: to bank `write_addr`
- `wr_data` out WORD_SIZE: to bank `data_in`

## Operation
- **Arbitration, per cycle:**
  - ALU wins when `alu_valid & alu_rd!=0`.
  - Otherwise the load FIFO head is popped and written if the FIFO is non-empty.
  - ALU results with `alu_rd==0` are dropped and do not occupy the port.
- **Load FIFO:**
  - `ld_ready = !full`, computed from the pre-pop occupancy; there is no same-cycle push-through when full.
  - Accepted loads with `ld_rd==0` are discarded and never enter the FIFO.
  - Pointers wrap modulo `LQ_DEPTH`.
  - Simultaneous push and pop leaves the count unchanged.
- **Write port:** `wr_en`, `wr_addr` and `wr_data` are registered.
  - `wr_en` pulses for exactly one cycle per committed result.
  - When `wr_en=0`, `wr_addr` and `wr_data` hold their previous values.
- **Scoreboard:** `busy[31:1]` with `busy[0]` hard 0.
  - `iss_valid & iss_rd!=0` sets `busy[iss_rd]` on the next edge.
  - `wr_en` clears `busy[wr_addr]` on the next edge.
  - Set and clear on the same rd in the same cycle: set wins.
- **Busy queries:** `busy_rs1`, `busy_rs2` and `busy_rd` are combinational.
  - Each equals `busy[x] & !(wr_en & wr_addr==x)`, which matches the bank's write-through bypass in the same cycle.
  - `x==0` always reports 0.
- **Issue protocol:** the issue stage must not assert `iss_valid` while `busy_rd=1`. Violating this is an assertion failure; RTL behaviour is then undefined.
- **Reset (`rstn` low):**
  - `wr_en=0`, `wr_addr=0`, `wr_data=0`.
  - FIFO empty; `busy` all 0.
  - `ld_ready=0` while in reset, `1` from the first cycle after release.
  - Reset mid-operation drops all queued loads and pending marks immediately.

## Timing
- ALU result sampled at edge N → `wr_en` high in cycle N+1, visible to bank reads in that cycle through the bypass.
- Load pushed at edge N → earliest `wr_en` in cycle N+2 (FIFO stage plus output register).
- A load waits one extra cycle for each consecutive ALU write that holds the port.
- Sustained throughput is one register write per cycle.
- `busy` clears at the edge ending the `wr_en` cycle. The issue stage may therefore read the register in the `wr_en` cycle itself (bypass) with `busy_rsX=0`.

## Structure
- Shared package `rv_core_pkg` holds:
  - `WORD_SIZE` and `REG_ADDR_W` constants
  - `typedef struct packed {logic [REG_ADDR_W-1:0] rd; logic [WORD_SIZE-1:0] data;} wb_req_t`
  - `localparam REG_ZERO = '0`
- One sub-module, `wb_load_fifo`: parameterised by depth, carries `wb_req_t`, has push/pop/full/empty.
- The arbiter, output register and scoreboard live in the top module.

## Test plan
- **ALU write:** reset release, `alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF` → next cycle `wr_en=1, wr_addr=5, wr_data=0xDEADBEEF`, one cycle only.
- **Contention:** ALU `rd=3` and load `rd=7, data=0x11` in the same cycle.
  - ALU write to x3 first, load write to x7 the next cycle.
  - `ld_ready` stays 1.
- **FIFO full and drain:** hold `alu_valid=1` (rd=1) and push 3 loads.
  - `ld_ready` falls after 2 accepts; the third is held.
  - Drop `alu_valid` → loads commit in order, one per cycle, and `ld_ready` returns to 1.
- **x0 suppression:** ALU `rd=0, data=0x55` and load `rd=0` → `wr_en` never asserts and the FIFO stays empty.
- **Scoreboard and bypass:**
  - `iss_valid, iss_rd=9` → `busy_rs1` is 1 next cycle with `chk_rs1=9`.
  - ALU write to x9 → `busy_rs1=0` during the `wr_en` cycle, and `busy[9]` stays 0 afterwards.
  - Set and clear of x9 in the same cycle leaves `busy[9]=1`.
- **Reset mid-operation:** 2 queued loads plus busy x4, assert `rstn=0` → `wr_en=0`, `ld_ready=0`, all busy 0, no writes after release.

Source files
------------

// File: rtl/rv_core_pkg.sv
// -----------------------------------------------------------------------------
// rv_core_pkg
// Shared core-wide constants and types for the writeback path.
//   WORD_SIZE   : register data width
//   REG_ADDR_W  : register address width (32 architectural registers)
//   REG_ZERO    : address of the hard-wired zero register
//   wb_req_t    : one pending register write (destination + data)
// -----------------------------------------------------------------------------
package rv_core_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WORD_SIZE-1:0]  data;
  } wb_req_t;

  // Writes aimed at x0 are architecturally discarded everywhere in the core.
  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] rd);
    return rd == REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// -----------------------------------------------------------------------------
// wb_load_fifo
// Small synchronous FIFO holding load results until the register bank write
// port is free.
//   clk, rstn  : clock, asynchronous active-low reset (empties the FIFO)
//   push       : enqueue push_data (ignored when full)
//   push_data  : load result to enqueue
//   pop        : dequeue the head entry (ignored when empty)
//   head       : current head entry, valid while !empty
//   full/empty : occupancy flags, from the current (pre-pop) count
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module wb_load_fifo
  import rv_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  wb_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign head      = r_mem[r_rd_ptr];

  // NOTE: sequential state is updated with <= only, so every flop samples the
  // pre-edge values and block ordering cannot change the result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; emptiness is defined by the
  // pointers/count alone, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
// Merges single-cycle ALU results and variable-latency load results onto the
// register bank's single write port, and keeps a pending-destination
// scoreboard for the issue stage's RAW/WAW stalls.
//   clk, rstn                 : clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data : ALU result, always accepted, has priority
//   ld_valid/ld_ready/ld_rd/ld_data : load result handshake into the FIFO
//   iss_valid/iss_rd          : mark iss_rd pending on the next edge
//   chk_rs1/chk_rs2           : issue-stage source queries
//   busy_rs1/busy_rs2/busy_rd : pending status, bypass-aware, combinational
//   wr_en/wr_addr/wr_data     : registered bank write port
// -----------------------------------------------------------------------------
module regfile_writeback
  import rv_core_pkg::*;
#(
  parameter int WORD_SIZE = rv_core_pkg::WORD_SIZE,
  parameter int ADDR_W    = rv_core_pkg::REG_ADDR_W,
  parameter int LQ_DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [WORD_SIZE-1:0] alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_W-1:0]    ld_rd,
  input  logic [WORD_SIZE-1:0] ld_data,
  input  logic                 iss_valid,
  input  logic [ADDR_W-1:0]    iss_rd,
  input  logic [ADDR_W-1:0]    chk_rs1,
  input  logic [ADDR_W-1:0]    chk_rs2,
  output logic                 busy_rs1,
  output logic                 busy_rs2,
  output logic                 busy_rd,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [WORD_SIZE-1:0] wr_data
);

  localparam int NREGS = 1 << ADDR_W;

  logic                 r_wr_en;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [WORD_SIZE-1:0] r_wr_data;
  logic [NREGS-1:0]     r_busy;

  logic             w_alu_win;
  logic             w_ld_push;
  logic             w_ld_pop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  wb_req_t          w_ld_req;
  wb_req_t          w_head;
  logic [NREGS-1:0] w_busy_set;
  logic [NREGS-1:0] w_busy_clr;
  logic [NREGS-1:0] w_busy_nxt;

  // ---------------------------------------------------------------------------
  // Arbitration: a real ALU write owns the port; otherwise drain one load.
  // ---------------------------------------------------------------------------
  assign w_alu_win = alu_valid & ~is_zero_reg(alu_rd);

  // Held low during reset so the load path cannot hand us data we would drop.
  assign ld_ready  = rstn & ~w_fifo_full;

  assign w_ld_push = ld_valid & ld_ready & ~is_zero_reg(ld_rd);
  assign w_ld_pop  = ~w_alu_win & ~w_fifo_empty;

  assign w_ld_req.rd   = ld_rd;
  assign w_ld_req.data = ld_data;

  wb_load_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_load_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (w_ld_push),
    .push_data (w_ld_req),
    .pop       (w_ld_pop),
    .head      (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Registered write port; address/data hold between writes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_alu_win | w_ld_pop;
      if (w_alu_win) begin
        r_wr_addr <= alu_rd;
        r_wr_data <= alu_data;
      end else if (w_ld_pop) begin
        r_wr_addr <= w_head.rd;
        r_wr_data <= w_head.data;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

  // ---------------------------------------------------------------------------
  // Scoreboard: the write in flight clears its bit at the end of the wr_en
  // cycle; a new issue to the same register in that cycle re-marks it.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // bit unassigned and no latch is inferred.
  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    if (iss_valid) w_busy_set[iss_rd] = 1'b1;
    if (r_wr_en)   w_busy_clr[r_wr_addr] = 1'b1;
    w_busy_nxt    = (r_busy & ~w_busy_clr) | w_busy_set;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  // A register being written this cycle reads correctly via the bank bypass,
  // so it no longer needs to stall the consumer.
  assign busy_rs1 = r_busy[chk_rs1] & ~(r_wr_en & (r_wr_addr == chk_rs1));
  assign busy_rs2 = r_busy[chk_rs2] & ~(r_wr_en & (r_wr_addr == chk_rs2));
  assign busy_rd  = r_busy[iss_rd]  & ~(r_wr_en & (r_wr_addr == iss_rd));

  // Issue must stall WAW hazards itself; re-marking a still-pending register
  // would let the older write clear the newer mark.
  always_ff @(posedge clk) begin
    if (rstn && iss_valid) assert (!busy_rd);
  end

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  localparam int W  = 32;
  localparam int A  = 5;
  localparam int LQ = 2;

  logic         clk = 1'b0;
  logic         rstn;
  logic         alu_valid;
  logic [A-1:0] alu_rd;
  logic [W-1:0] alu_data;
  logic         ld_valid;
  logic         ld_ready;
  logic [A-1:0] ld_rd;
  logic [W-1:0] ld_data;
  logic         iss_valid;
  logic [A-1:0] iss_rd;
  logic [A-1:0] chk_rs1;
  logic [A-1:0] chk_rs2;
  logic         busy_rs1;
  logic         busy_rs2;
  logic         busy_rd;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [W-1:0] wr_data;

  always #5 clk = ~clk;

  regfile_writeback #(
    .WORD_SIZE (W),
    .ADDR_W    (A),
    .LQ_DEPTH  (LQ)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .busy_rs1  (busy_rs1),
    .busy_rs2  (busy_rs2),
    .busy_rd   (busy_rd),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a queue of waiting loads, a set of pending registers and
  // the write that is visible on the port this cycle.
  typedef struct {
    logic [A-1:0] rd;
    logic [W-1:0] data;
  } ld_t;

  ld_t          m_q[$];
  bit           m_busy[32];
  logic         m_wr_en;
  logic [A-1:0] m_wr_addr;
  logic [W-1:0] m_wr_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_wr_en   = 1'b0;
    m_wr_addr = '0;
    m_wr_data = '0;
  endtask

  function automatic logic m_query(input logic [A-1:0] x);
    if (x == 0) return 1'b0;
    return m_busy[x] && !(m_wr_en && m_wr_addr == x);
  endfunction

  task automatic compare_all();
    check("ld_ready", ld_ready, rstn ? logic'(m_q.size() < LQ) : 1'b0);
    check("wr_en",    wr_en,    m_wr_en);
    check("wr_addr",  wr_addr,  m_wr_addr);
    check("wr_data",  wr_data,  m_wr_data);
    check("busy_rs1", busy_rs1, m_query(chk_rs1));
    check("busy_rs2", busy_rs2, m_query(chk_rs2));
    check("busy_rd",  busy_rd,  m_query(iss_rd));
  endtask

  // Apply one clock edge to the model using the inputs held across it.
  task automatic advance();
    logic         c_en;
    logic [A-1:0] c_addr;
    logic [W-1:0] c_data;
    bit           room;
    ld_t          h;
    if (!rstn) begin
      model_reset();
      return;
    end
    room   = m_q.size() < LQ;
    c_en   = 1'b0;
    c_addr = m_wr_addr;
    c_data = m_wr_data;
    if (alu_valid && alu_rd != 0) begin
      c_en   = 1'b1;
      c_addr = alu_rd;
      c_data = alu_data;
    end else if (m_q.size() > 0) begin
      h      = m_q.pop_front();
      c_en   = 1'b1;
      c_addr = h.rd;
      c_data = h.data;
    end
    if (ld_valid && room && ld_rd != 0) m_q.push_back('{rd: ld_rd, data: ld_data});
    if (m_wr_en) m_busy[m_wr_addr] = 1'b0;
    if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    m_wr_en   = c_en;
    m_wr_addr = c_addr;
    m_wr_data = c_data;
  endtask

  // Inputs are driven at the falling edge; outputs compared 1 time unit later.
  task automatic tick();
    #1 compare_all();
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
    iss_valid = 1'b0; iss_rd = '0;
    chk_rs1   = '0;   chk_rs2 = '0;
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    model_reset();

    // Reset state
    @(negedge clk);
    #1;
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_wr_en",    wr_en,    1'b0);
    check("rst_wr_data",  wr_data,  32'h0);
    tick();
    rstn = 1'b1;
    #1 check("rel_ld_ready", ld_ready, 1'b1);
    tick();

    // ALU write, single-cycle pulse, held data afterwards
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    #1;
    check("alu_wr_en",   wr_en,   1'b1);
    check("alu_wr_addr", wr_addr, 5'd5);
    check("alu_wr_data", wr_data, 32'hDEADBEEF);
    tick();
    #1;
    check("alu_pulse_end", wr_en,   1'b0);
    check("alu_hold_data", wr_data, 32'hDEADBEEF);
    tick();

    // Contention: ALU first, load the following cycle
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    ld_valid  = 1'b1; ld_rd  = 5'd7; ld_data  = 32'h11;
    #1 check("cont_ld_ready", ld_ready, 1'b1);
    tick();
    idle_inputs();
    #1;
    check("cont_first",  wr_addr, 5'd3);
    check("cont_rdy",    ld_ready, 1'b1);
    tick();
    #1;
    check("cont_ld_en",   wr_en,   1'b1);
    check("cont_ld_addr", wr_addr, 5'd7);
    check("cont_ld_data", wr_data, 32'h11);
    tick();

    // FIFO full and drain
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    ld_valid  = 1'b1; ld_rd  = 5'd10; ld_data = 32'hA0;
    tick();
    ld_rd = 5'd11; ld_data = 32'hA1;
    tick();
    ld_rd = 5'd12; ld_data = 32'hA2;
    #1 check("full_rdy0", ld_ready, 1'b0);
    tick();
    alu_valid = 1'b0;
    #1 check("full_rdy1", ld_ready, 1'b0);
    tick();
    #1;
    check("drain0_addr", wr_addr, 5'd10);
    check("drain0_rdy",  ld_ready, 1'b1);
    tick();
    ld_valid = 1'b0;
    #1 check("drain1_addr", wr_addr, 5'd11);
    tick();
    #1;
    check("drain2_addr", wr_addr, 5'd12);
    check("drain2_data", wr_data, 32'hA2);
    tick();
    #1 check("drain_done", wr_en, 1'b0);
    tick();

    // x0 suppression
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    ld_valid  = 1'b1; ld_rd  = 5'd0; ld_data  = 32'h66;
    tick();
    idle_inputs();
    #1 check("x0_no_wr", wr_en, 1'b0);
    tick();
    #1;
    check("x0_fifo_empty", wr_en,   1'b0);
    check("x0_hold_data",  wr_data, 32'hA2);
    tick();

    // Scoreboard and bypass
    iss_valid = 1'b1; iss_rd = 5'd9; chk_rs1 = 5'd9;
    tick();
    iss_valid = 1'b0;
    #1 check("sb_set", busy_rs1, 1'b1);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    tick();
    alu_valid = 1'b0;
    #1;
    check("sb_bypass_en", wr_en,    1'b1);
    check("sb_bypass",    busy_rs1, 1'b0);
    tick();
    #1 check("sb_cleared", busy_rs1, 1'b0);
    iss_valid = 1'b1;
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b1;
    tick();
    // Re-issue x9 in its own wr_en cycle: set must win over the clear.
    alu_valid = 1'b0; iss_valid = 1'b1;
    #1 check("sb_rd_bypass", busy_rd, 1'b0);
    tick();
    iss_valid = 1'b0;
    #1 check("sb_set_wins", busy_rs1, 1'b1);
    alu_valid = 1'b1;
    tick();
    idle_inputs();
    tick();

    // Reset mid-operation
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h2;
    ld_valid  = 1'b1; ld_rd  = 5'd13; ld_data = 32'hD0;
    iss_valid = 1'b1; iss_rd = 5'd4; chk_rs1 = 5'd4;
    tick();
    iss_valid = 1'b0; ld_rd = 5'd14; ld_data = 32'hD1;
    tick();
    ld_valid = 1'b0;
    #1 check("mid_busy_pre", busy_rs1, 1'b1);
    rstn = 1'b0;
    alu_valid = 1'b0;
    model_reset();
    #1;
    check("mid_wr_en",    wr_en,    1'b0);
    check("mid_ld_ready", ld_ready, 1'b0);
    check("mid_busy",     busy_rs1, 1'b0);
    tick();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("mid_no_wr", wr_en, 1'b0);
      tick();
    end

    // Randomized traffic against the reference model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!rstn) begin
        rstn = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        rstn = 1'b0;
        model_reset();
      end
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 1) == 0);
      ld_rd     = 5'($urandom_range(0, 7));
      ld_data   = $urandom;
      chk_rs1   = 5'($urandom_range(0, 7));
      chk_rs2   = 5'($urandom_range(0, 7));
      iss_rd    = 5'($urandom_range(0, 7));
      iss_valid = ($urandom_range(0, 2) == 0) && !m_query(iss_rd);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
